mg_seq_div: RTL and testbench

MG_SEQ_DIV -- requirements
Module: mg_seq_div

---
 rtl/mg_seq_div_if.sv | 24 ++
 rtl/mg_seq_div.sv | 103 ++++++++++
 tb/tb_mg_seq_div.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mg_seq_div_if.sv
// Handshake bundle for mg_seq_div: operand request channel and result channel.
interface mg_seq_div_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dz
  );
endinterface

// File: rtl/mg_seq_div.sv
// mg_seq_div: unsigned radix-2 restoring divider, one quotient bit per clock.
// IDLE accepts an operand pair, BUSY runs WIDTH iterations, DONE holds the
// result until the consumer takes it.
// Optional feature macro MG_DIV_DZ_FAST_EN: a zero divisor skips BUSY and the
// result is presented one edge after accept (values identical either way).
module mg_seq_div #(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  mg_seq_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int unsigned   CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             dz_r;

  logic             accept;
  logic             fast_dz;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             unused_diff_msb;

  assign accept = (state == IDLE) && bus.in_valid;

`ifdef MG_DIV_DZ_FAST_EN
  assign fast_dz = (bus.divisor == '0);
`else
  assign fast_dz = 1'b0;
`endif

  // Partial remainder after the left shift, and its trial subtraction.
  // A zero divisor never borrows, so the plain iteration already yields
  // quotient = all ones and remainder = dividend.
  assign partial = {rem, quo[WIDTH-1]};
  assign {borrow, diff} = {1'b0, partial} - {2'b00, dvs};
  // diff[WIDTH] is zero whenever the difference is kept.
  assign unused_diff_msb = diff[WIDTH];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.in_valid)     state_nxt = fast_dz ? DONE : BUSY;
      BUSY: if (cnt == LAST)      state_nxt = DONE;
      DONE: if (bus.out_ready)    state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, one restoring iteration per BUSY edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      dz_r <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      dvs  <= bus.divisor;
      dz_r <= (bus.divisor == '0);
      cnt  <= '0;
      if (fast_dz) begin
        quo <= '1;
        rem <= bus.dividend;
      end else begin
        quo <= bus.dividend;
        rem <= '0;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      if (borrow) begin
        rem <= partial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end else begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = quo;
  assign bus.remainder = rem;
  assign bus.dz        = dz_r;

endmodule

// File: tb/tb_mg_seq_div.sv
// Directed bench for mg_seq_div (WIDTH=8) with hand-computed results.
module tb_mg_seq_div;

  localparam int unsigned W = 8;

`ifdef MG_DIV_DZ_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = W + 1;
`endif
  localparam int LAT = W + 1;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mg_seq_div_if #(.WIDTH(W)) bus ();

  mg_seq_div #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_quotient"},  32'(bus.quotient),  0);
    check({tag, "_remainder"}, 32'(bus.remainder), 0);
    check({tag, "_dz"},        32'(bus.dz),        0);
  endtask

  // One transaction: accept, wait for the result with a bounded latency
  // count (accept edge counted as edge 1), optional backpressure hold,
  // optional in_valid/operand churn while busy, then release.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int eq, input int er, input int edz, input int elat,
                        input int hold, input bit toggle);
    int lat;
    @(negedge clk);
    check({tag, "_rdy_pre"}, 32'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.out_ready = 1'b0;
    @(negedge clk);
    lat = 1;
    check({tag, "_rdy_post"}, 32'(bus.in_ready), 0);
    if (!toggle) bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (toggle) begin
        bus.in_valid = ~bus.in_valid;
        bus.dividend = 8'($urandom);
        bus.divisor  = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"},   32'(lat),           32'(elat));
    check({tag, "_quotient"},  32'(bus.quotient),  32'(eq));
    check({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
    check({tag, "_dz"},        32'(bus.dz),        32'(edz));
    check({tag, "_rdy_done"},  32'(bus.in_ready),  0);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({tag, "_hold_valid"},     32'(bus.out_valid), 1);
      check({tag, "_hold_quotient"},  32'(bus.quotient),  32'(eq));
      check({tag, "_hold_remainder"}, 32'(bus.remainder), 32'(er));
      check({tag, "_hold_dz"},        32'(bus.dz),        32'(edz));
    end
    bus.out_ready = 1'b1;
    if (toggle) bus.in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_valid_after"}, 32'(bus.out_valid), 0);
    check({tag, "_rdy_after"},   32'(bus.in_ready),  1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("d100_7",  8'd100, 8'd7,   14,  2,   0, LAT,    0, 1'b0);
    run_op("d5_0",    8'd5,   8'd0,   255, 5,   1, DZ_LAT, 0, 1'b0);
    run_op("d255_1",  8'd255, 8'd1,   255, 0,   0, LAT,    0, 1'b0);
    run_op("d0_3",    8'd0,   8'd3,   0,   0,   0, LAT,    0, 1'b0);
    run_op("d200_13", 8'd200, 8'd13,  15,  5,   0, LAT,    5, 1'b0);
    run_op("d7_100",  8'd7,   8'd100, 0,   7,   0, LAT,    0, 1'b0);
    run_op("d255_255",8'd255, 8'd255, 1,   0,   0, LAT,    0, 1'b0);
    run_op("d0_0",    8'd0,   8'd0,   255, 0,   1, DZ_LAT, 0, 1'b0);

    // Abort 77/6 part-way through BUSY with an asynchronous reset pulse.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 8'd77;
    bus.divisor  = 8'd6;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(bus.out_valid), 0);
    end
    run_op("d77_6",   8'd77,  8'd6,   12,  5,   0, LAT,    0, 1'b0);

    run_op("d50_4",   8'd50,  8'd4,   12,  2,   0, LAT,    0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
